// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Instruction producer for the decode path. It holds the PC, issues word
// fetches to an instruction memory with a fixed one-cycle response latency,
// buffers the returned words in a DEPTH-entry FIFO, and presents the head
// entry to decode over a valid/ready handshake. Branch redirects flush the
// FIFO, kill any in-flight response and restart fetch at the target.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  PC loaded on reset (word aligned)
//
// Ports:
//   Clk           clock, rising edge
//   Rst           synchronous active-low reset
//   IMemReq       fetch request this cycle (combinational)
//   IMemAddr      fetch byte address = current PC (combinational)
//   IMemData      instruction word, valid one cycle after an accepted request
//   BranchTaken   redirect strobe
//   BranchTarget  redirect byte address (low two bits ignored)
//   InstrValid    head entry valid
//   InstrReady    decode accepts head
//   Instruction   head instruction word (0 when empty)
//   InstrPC       byte address of head instruction (0 when empty)
//   Count         occupied FIFO entries, 0..DEPTH
//
// Optional build macro:
//   FETCH_PERF_CNT_EN  adds FetchCount (accepted requests) and FlushCount
//                      (redirect cycles), both 32-bit wrapping counters.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       Clk,
    input  logic                       Rst,
    output logic                       IMemReq,
    output logic [31:0]                IMemAddr,
    input  logic [31:0]                IMemData,
    input  logic                       BranchTaken,
    input  logic [31:0]                BranchTarget,
    output logic                       InstrValid,
    input  logic                       InstrReady,
    output logic [31:0]                Instruction,
    output logic [31:0]                InstrPC,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                FetchCount,
    output logic [31:0]                FlushCount,
`endif
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    // Capacity compared against entries held plus the one reserved in flight.
    localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);

    logic [31:0]   pc_r;
    logic [31:0]   tag_r;
    logic          inflight_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [31:0]   data_mem_r [DEPTH];
    logic [31:0]   pc_mem_r   [DEPTH];

    logic [CW:0]   occupancy_s;
    logic          req_s;
    logic          enq_s;
    logic          deq_s;
    logic          head_valid_s;
    logic          unused_target_bits_s;

    // The low target bits are forced to zero, so they never reach state.
    assign unused_target_bits_s = ^BranchTarget[1:0];

    // Request/handshake decisions for the current cycle.
    always_comb begin
        occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
        head_valid_s = (count_r != CNT_ZERO);
        enq_s        = inflight_r;
        deq_s        = head_valid_s && InstrReady;
        // A request reserves its FIFO slot up front, so the FIFO never overflows.
        if (Rst && !BranchTaken && (occupancy_s < CAP)) begin
            req_s = 1'b1;
        end else begin
            req_s = 1'b0;
        end
    end

    assign IMemReq    = req_s;
    assign IMemAddr   = pc_r;
    assign Count      = count_r;
    assign InstrValid = head_valid_s;

    // Head entry presented to decode; an empty FIFO shows a NOP at PC 0.
    always_comb begin
        if (head_valid_s) begin
            Instruction = data_mem_r[rd_ptr_r];
            InstrPC     = pc_mem_r[rd_ptr_r];
        end else begin
            Instruction = 32'h0000_0000;
            InstrPC     = 32'h0000_0000;
        end
    end

    // PC, in-flight tracking and FIFO pointer/occupancy state.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            pc_r       <= RESET_PC;
            tag_r      <= 32'h0000_0000;
            inflight_r <= 1'b0;
            count_r    <= CNT_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
        end else if (BranchTaken) begin
            // Redirect: flush, drop the in-flight response, ignore any dequeue.
            pc_r       <= {BranchTarget[31:2], 2'b00};
            inflight_r <= 1'b0;
            count_r    <= CNT_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            wr_ptr_r   <= PTR_ZERO;
        end else begin
            if (enq_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (enq_s && !deq_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!enq_s && deq_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
            if (req_s) begin
                pc_r  <= pc_r + 32'd4;
                tag_r <= pc_r;
            end
            inflight_r <= req_s;
        end
    end

    // FIFO storage: the response arriving this cycle lands at the tail.
    always_ff @(posedge Clk) begin
        if (Rst && !BranchTaken && enq_s) begin
            data_mem_r[wr_ptr_r] <= IMemData;
            pc_mem_r[wr_ptr_r]   <= tag_r;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_r;
    logic [31:0] flush_count_r;

    // Performance counters for accepted fetches and redirect cycles.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            fetch_count_r <= 32'h0000_0000;
            flush_count_r <= 32'h0000_0000;
        end else begin
            if (req_s) begin
                fetch_count_r <= fetch_count_r + 32'd1;
            end
            if (BranchTaken) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
        end
    end

    assign FetchCount = fetch_count_r;
    assign FlushCount = flush_count_r;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Drives directed and randomized cycles into instr_fetch_queue. A reference
// model (a queue of expected {word, pc} entries, a PC and an in-flight flag)
// predicts requests and FIFO contents; a separate monitor process compares
// the decode-side outputs against the expected queue each cycle and pops it
// on every handshake.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DMASK    = 32'hA5A5_0000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic [$clog2(DEPTH+1)-1:0] Count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;
`endif

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemData    (IMemData),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Instruction (Instruction),
        .InstrPC     (InstrPC),
`ifdef FETCH_PERF_CNT_EN
        .FetchCount  (FetchCount),
        .FlushCount  (FlushCount),
`endif
        .Count       (Count)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];     // {expected word, expected pc}
    logic [31:0] m_pc;
    logic        m_inflight;
    logic [31:0] m_tag;
    logic        checking;
    logic        last_req;
    logic [31:0] last_addr;
    event        sample_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check fetch side, then advance the model.
    task automatic drive(input logic r, input logic b, input logic [31:0] t, input logic rd);
        logic exp_req;
        @(negedge Clk);
        Rst          = r;
        BranchTaken  = b;
        BranchTarget = t;
        InstrReady   = rd;
        // Memory answers the request accepted at the previous edge.
        IMemData     = last_req ? (last_addr ^ DMASK) : $urandom;
        #1;
        exp_req = r && !b && ((exp_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
        if (checking) begin
            check("imemreq", 32'(IMemReq), 32'(exp_req));
            check("imemaddr", IMemAddr, m_pc);
        end
        last_req  = IMemReq;
        last_addr = IMemAddr;
        -> sample_ev;
        #1;
        // Model state after the coming rising edge.
        if (!r) begin
            exp_q.delete();
            m_pc       = RESET_PC;
            m_inflight = 1'b0;
            checking   = 1'b1;
`ifdef FETCH_PERF_CNT_EN
            m_fetch = 32'd0;
            m_flush = 32'd0;
`endif
        end else if (b) begin
            exp_q.delete();
            m_pc       = t & 32'hFFFF_FFFC;
            m_inflight = 1'b0;
`ifdef FETCH_PERF_CNT_EN
            m_flush = m_flush + 32'd1;
`endif
        end else begin
            if (m_inflight) exp_q.push_back({m_tag ^ DMASK, m_tag});
            if (exp_req) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd4;
`ifdef FETCH_PERF_CNT_EN
                m_fetch = m_fetch + 32'd1;
`endif
            end
            m_inflight = exp_req;
        end
    endtask

    // Monitor: compare decode-side outputs and pop on each handshake.
    initial begin
        forever begin
            @(sample_ev);
            if (checking) begin
                check("count", 32'(Count), 32'(exp_q.size()));
                check("valid", 32'(InstrValid), 32'(exp_q.size() != 0));
`ifdef FETCH_PERF_CNT_EN
                check("fetchcount", FetchCount, m_fetch);
                check("flushcount", FlushCount, m_flush);
`endif
                if (exp_q.size() == 0) begin
                    check("nop", Instruction, 32'h0000_0000);
                end else begin
                    check("instr", Instruction, exp_q[0][63:32]);
                    check("instrpc", InstrPC, exp_q[0][31:0]);
                    if (InstrReady && Rst && !BranchTaken) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic        r, b, rd;
        logic [31:0] t;
        Rst = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0; InstrReady = 1'b1;
        IMemData = 32'h0; checking = 1'b0; last_req = 1'b0; last_addr = 32'h0;
        m_pc = RESET_PC; m_inflight = 1'b0; m_tag = 32'h0;
`ifdef FETCH_PERF_CNT_EN
        m_fetch = 32'd0; m_flush = 32'd0;
`endif
        // Reset, then streaming with decode always ready.
        repeat (3) drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (8) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Redirect with a request in flight, unaligned target, wrap at 2^32.
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'h0000_0103, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Back-to-back redirects: last one wins.
        drive(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Fill to full with decode stalled, then drain.
        repeat (2) drive(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Reset mid-operation with entries buffered and a request in flight.
        drive(1'b1, 1'b1, 32'h0000_0040, 1'b0);
        repeat (4) drive(1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (6) drive(1'b1, 1'b0, 32'h0, 1'b1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(99) >= 2);
            b  = ($urandom_range(99) < 8);
            rd = ($urandom_range(99) < 65);
            if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            else t = $urandom;
            drive(r, b, t, rd);
        end
        repeat (8) drive(1'b1, 1'b0, 32'h0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
